// File: rtl/apb_master_mux_rr.sv
// N-way APB master multiplexer with round-robin arbitration and registered request/response paths.
// Define APB_MUX_TIMEOUT_EN to turn target hangs into error completions after TIMEOUT_CYCLES access cycles.
//
// state  | meaning
// IDLE   | arbitrate among pending m_psel bits
// SETUP  | downstream psel=1, penable=0
// ACCESS | downstream psel=1, penable=1, waiting for target pready
// DONE   | one-cycle m_pready pulse to the granted master
module apb_master_mux_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      clk__enable,
    input  logic                      reset_n,
    input  logic [NUM_MASTERS-1:0]    m_psel,
    input  logic [NUM_MASTERS-1:0]    m_penable,
    input  logic [NUM_MASTERS-1:0]    m_pwrite,
    input  logic [32*NUM_MASTERS-1:0] m_paddr,
    input  logic [32*NUM_MASTERS-1:0] m_pwdata,
    output logic [31:0]               m_prdata,
    output logic [NUM_MASTERS-1:0]    m_pready,
    output logic                      m_perr,
    output logic [31:0]               apb_request__paddr,
    output logic                      apb_request__penable,
    output logic                      apb_request__psel,
    output logic                      apb_request__pwrite,
    output logic [31:0]               apb_request__pwdata,
    input  logic [31:0]               apb_response__prdata,
    input  logic                      apb_response__pready,
    input  logic                      apb_response__perr,
    output logic                      busy,
    output logic [2:0]                grant_idx
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]             state;
    logic [2:0]             last_grant;
    logic [7:0]             psel_pad;
    logic [3:0]             cand;
    logic                   req_any;
    logic [2:0]             next_grant;
    logic [31:0]            paddr_sel;
    logic [31:0]            pwdata_sel;
    logic                   pwrite_sel;
    logic [NUM_MASTERS-1:0] grant_onehot;

    assign psel_pad     = 8'(m_psel);
    assign busy         = (state != ST_IDLE);
    assign grant_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant_idx;

    // Search starts just past the last winner, so a master cannot win twice while others wait.
    always_comb begin
        req_any    = 1'b0;
        next_grant = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = {1'b0, last_grant} + 4'(k);
            if (cand >= 4'(NUM_MASTERS))
                cand = cand - 4'(NUM_MASTERS);
            if (!req_any && psel_pad[cand[2:0]]) begin
                req_any    = 1'b1;
                next_grant = cand[2:0];
            end
        end
    end

    always_comb begin
        paddr_sel  = '0;
        pwdata_sel = '0;
        pwrite_sel = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (3'(i) == next_grant) begin
                paddr_sel  = m_paddr[32*i +: 32];
                pwdata_sel = m_pwdata[32*i +: 32];
                pwrite_sel = m_pwrite[i];
            end
        end
    end

`ifdef APB_MUX_TIMEOUT_EN
    logic [15:0] tcnt;
    logic        unused_ok;
    assign unused_ok = ^m_penable;
`else
    // m_penable and TIMEOUT_CYCLES play no part in this build.
    logic unused_ok;
    assign unused_ok = ^{m_penable, 16'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            last_grant           <= 3'(NUM_MASTERS - 1);
            grant_idx            <= '0;
            apb_request__paddr   <= '0;
            apb_request__pwdata  <= '0;
            apb_request__pwrite  <= 1'b0;
            apb_request__psel    <= 1'b0;
            apb_request__penable <= 1'b0;
            m_prdata             <= '0;
            m_perr               <= 1'b0;
            m_pready             <= '0;
`ifdef APB_MUX_TIMEOUT_EN
            tcnt                 <= '0;
`endif
        end else if (clk__enable) begin
            m_pready <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        grant_idx           <= next_grant;
                        last_grant          <= next_grant;
                        apb_request__paddr  <= paddr_sel;
                        apb_request__pwdata <= pwdata_sel;
                        apb_request__pwrite <= pwrite_sel;
                        apb_request__psel   <= 1'b1;
                        state               <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb_request__penable <= 1'b1;
                    state                <= ST_ACCESS;
`ifdef APB_MUX_TIMEOUT_EN
                    tcnt                 <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (apb_response__pready) begin
                        m_prdata             <= apb_response__prdata;
                        m_perr               <= apb_response__perr;
                        apb_request__psel    <= 1'b0;
                        apb_request__penable <= 1'b0;
                        m_pready             <= grant_onehot;
                        state                <= ST_DONE;
                    end
`ifdef APB_MUX_TIMEOUT_EN
                    else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        m_prdata             <= '0;
                        m_perr               <= 1'b1;
                        apb_request__psel    <= 1'b0;
                        apb_request__penable <= 1'b0;
                        m_pready             <= grant_onehot;
                        state                <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
